// File: rtl/ram_access_controller.sv
// ram_access_controller: valid/ready front end that serialises host reads/writes onto one single-port RAM,
// with a hardware sweep-clear. Define RAM_CTRL_VERIFY_EN to add write-readback verification.
module ram_access_controller #(
  parameter int memory_height = 8,
  parameter int address_width = 3,
  parameter int data_width    = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [address_width-1:0] req_address,
  input  logic [data_width-1:0]    req_data,
  output logic                     rsp_valid,
  output logic [data_width-1:0]    rsp_data,
  input  logic                     rsp_ready,
  input  logic                     clear_start,
  output logic                     busy,
  output logic                     verify_error,
  output logic [address_width-1:0] ram_address,
  output logic                     ram_read_or_write,
  output logic [data_width-1:0]    ram_wdata,
  input  logic [data_width-1:0]    ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    RESP,
    CLEAR
`ifdef RAM_CTRL_VERIFY_EN
    ,
    VFY_READ,
    VFY_WAIT
`endif
  } state_t;

  localparam logic [address_width-1:0] LAST_ADDR = address_width'(memory_height - 1);

  state_t                     state, state_next;
  logic [address_width-1:0]   addr_next;
  logic                       rw_next;
  logic [data_width-1:0]      wdata_next;
  logic                       rsp_valid_next;
  logic [data_width-1:0]      rsp_data_next;
  logic                       busy_next;
  logic                       verr_next;

  assign req_ready = (state == IDLE) && !clear_start;

  always_comb begin
    state_next     = state;
    addr_next      = ram_address;
    rw_next        = 1'b0;
    wdata_next     = ram_wdata;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    verr_next      = verify_error;
    unique case (state)
      IDLE: begin
        if (clear_start) begin
          state_next = CLEAR;
          addr_next  = '0;
          wdata_next = '0;
          rw_next    = 1'b1;
          verr_next  = 1'b0;
        end else if (req_valid) begin
          addr_next  = req_address;
          wdata_next = req_data;
          if (req_write) begin
            state_next = WRITE;
            rw_next    = 1'b1;
          end else begin
            state_next = READ;
          end
        end
      end
      WRITE: begin
`ifdef RAM_CTRL_VERIFY_EN
        state_next = VFY_READ;
`else
        state_next = IDLE;
`endif
      end
      READ:      state_next = READ_WAIT;
      READ_WAIT: begin
        rsp_data_next  = ram_rdata;
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      // Strobe high selects a write cycle; once the last address is written one
      // idle-strobe cycle remains in CLEAR before returning (memory_height+1 busy cycles).
      CLEAR: begin
        if (ram_read_or_write) begin
          if (ram_address != LAST_ADDR) begin
            addr_next = ram_address + 1'b1;
            rw_next   = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
`ifdef RAM_CTRL_VERIFY_EN
      VFY_READ:  state_next = VFY_WAIT;
      VFY_WAIT: begin
        if (ram_rdata != ram_wdata) verr_next = 1'b1;
        state_next = IDLE;
      end
`endif
      default:   state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      ram_address       <= '0;
      ram_read_or_write <= 1'b0;
      ram_wdata         <= '0;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      busy              <= 1'b0;
    end else begin
      state             <= state_next;
      ram_address       <= addr_next;
      ram_read_or_write <= rw_next;
      ram_wdata         <= wdata_next;
      rsp_valid         <= rsp_valid_next;
      rsp_data          <= rsp_data_next;
      busy              <= busy_next;
    end
  end

`ifdef RAM_CTRL_VERIFY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) verify_error <= 1'b0;
    else          verify_error <= verr_next;
  end
`else
  assign verify_error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_controller.sv
// Self-checking bench for ram_access_controller: behavioural RAM plus transaction-level reference model.
module tb_ram_access_controller;
  localparam int MH = 8;
  localparam int AW = 3;
  localparam int DW = 4;
`ifdef RAM_CTRL_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready = 1'b0;
  logic          clear_start = 1'b0;
  logic          busy;
  logic          verify_error;
  logic [AW-1:0] ram_address;
  logic          ram_read_or_write;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] ref_mem [MH];
  bit            err_model = 1'b0;

  ram_access_controller #(
    .memory_height(MH),
    .address_width(AW),
    .data_width   (DW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_address      (req_address),
    .req_data         (req_data),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_ready        (rsp_ready),
    .clear_start      (clear_start),
    .busy             (busy),
    .verify_error     (verify_error),
    .ram_address      (ram_address),
    .ram_read_or_write(ram_read_or_write),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata)
  );

  always #5 clock = ~clock;

  // Single-port RAM with registered read; optional stuck-at-0 on bit 0 of address 3.
  logic [DW-1:0] mem [MH];
  bit            stuck_en = 1'b0;
  always @(posedge clock) begin
    if (ram_read_or_write)
      mem[ram_address] <= (stuck_en && ram_address == AW'(3)) ? {ram_wdata[DW-1:1], 1'b0} : ram_wdata;
    ram_rdata <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] stored;
    wait_ready();
    stored = (stuck_en && a == AW'(3)) ? {d[DW-1:1], 1'b0} : d;
    req_valid = 1'b1; req_write = 1'b1; req_address = a; req_data = d;
    tick();
    req_valid = 1'b0;
    check("wr_rw", 32'(ram_read_or_write), 32'd1);
    check("wr_addr", 32'(ram_address), 32'(a));
    check("wr_data", 32'(ram_wdata), 32'(d));
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_ready_low", 32'(req_ready), 32'd0);
    ref_mem[a] = stored;
    tick();
    check("wr_rw_pulse", 32'(ram_read_or_write), 32'd0);
    if (VFY) begin
      if (stored != d) err_model = 1'b1;
      check("vfy_busy1", 32'(busy), 32'd1);
      tick();
      check("vfy_busy2", 32'(busy), 32'd1);
      check("vfy_rw", 32'(ram_read_or_write), 32'd0);
      tick();
    end
    check("wr_busy_done", 32'(busy), 32'd0);
    check("wr_ready_back", 32'(req_ready), 32'd1);
    check("wr_verify_error", 32'(verify_error), 32'(err_model));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int unsigned bp);
    logic [DW-1:0] exp;
    wait_ready();
    exp = ref_mem[a];
    req_valid = 1'b1; req_write = 1'b0; req_address = a;
    rsp_ready = (bp == 0);
    tick();
    req_valid = 1'b0;
    check("rd_addr", 32'(ram_address), 32'(a));
    check("rd_rw", 32'(ram_read_or_write), 32'd0);
    check("rd_ready_low", 32'(req_ready), 32'd0);
    tick();
    check("rd_valid_early", 32'(rsp_valid), 32'd0);
    tick();
    check("rd_valid", 32'(rsp_valid), 32'd1);
    check("rd_data", 32'(rsp_data), 32'(exp));
    for (int unsigned i = 0; i < bp; i++) begin
      tick();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(exp));
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("rsp_done", 32'(rsp_valid), 32'd0);
    check("rd_ready_back", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  task automatic do_clear(input bit with_req, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    clear_start = 1'b1;
    if (with_req) begin
      req_valid = 1'b1; req_write = 1'b1; req_address = a; req_data = d;
    end
    tick();
    clear_start = 1'b0;
    check("clr_verify_error", 32'(verify_error), 32'd0);
    for (int k = 0; k <= MH; k++) begin
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_ready_low", 32'(req_ready), 32'd0);
      check("clr_rw", 32'(ram_read_or_write), 32'(k < MH));
      if (k < MH) begin
        check("clr_addr", 32'(ram_address), 32'(k));
        check("clr_wdata", 32'(ram_wdata), 32'd0);
      end
      tick();
    end
    check("clr_busy_done", 32'(busy), 32'd0);
    for (int i = 0; i < MH; i++) ref_mem[i] = '0;
    err_model = 1'b0;
    if (with_req) begin
      check("clr_ready_back", 32'(req_ready), 32'd1);
      do_write(a, d);
    end
  endtask

  initial begin
    #2;
    check("rst_rw", 32'(ram_read_or_write), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_verify_error", 32'(verify_error), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    do_clear(1'b0, '0, '0);

    do_write(AW'(5), DW'(4'hA));
    do_read(AW'(5), 0);
    do_read(AW'(5), 10);

    do_clear(1'b1, AW'(2), DW'(7));
    for (int i = 0; i < MH; i++) do_read(AW'(i), 0);

    // Stuck-bit write at address 3: flags only when readback verify is built in.
    stuck_en = 1'b1;
    do_write(AW'(3), DW'(5));
    check("vfy_flag", 32'(verify_error), 32'(VFY));
    do_read(AW'(3), 0);
    do_write(AW'(6), DW'(3));
    do_write(AW'(3), DW'(4));
    check("vfy_sticky", 32'(verify_error), 32'(VFY));
    do_clear(1'b0, '0, '0);
    check("vfy_cleared", 32'(verify_error), 32'd0);
    stuck_en = 1'b0;

    for (int n = 0; n < 150; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 45)
        do_write(AW'($urandom_range(0, MH - 1)), DW'($urandom));
      else if (r < 92)
        do_read(AW'($urandom_range(0, MH - 1)), $urandom_range(0, 3));
      else
        do_clear(1'($urandom), AW'($urandom_range(0, MH - 1)), DW'($urandom));
    end

    // Reset while in READ_WAIT: response must be dropped.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_address = AW'(5); rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_rw", 32'(ram_read_or_write), 32'd0);
    check("mid_rst_addr", 32'(ram_address), 32'd0);
    check("mid_rst_wdata", 32'(ram_wdata), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_verify_error", 32'(verify_error), 32'd0);
    tick();
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    reset_n = 1'b1;
    err_model = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    tick();
    check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
    do_read(AW'(5), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
